miriscv_hazard_scoreboard: RTL and testbench
============================================

Name: miriscv_hazard_scoreboard

Overview:
- Parametrised hazard/forwarding unit for the MIRISCV pipeline.
- Generalises the fixed E/M bypass select to NUM_SRC source operands and adds a writeback (W) bypass.
- Adds a per-register scoreboard of pending long-latency writes (loads, MDU) so multicycle results stall dependants until available.
- Sits beside decode/issue; drives operand bypass muxes and the issue stall.

Parameters:
- NUM_SRC, 2, number of source operands checked per issued instruction (2..3).
- CNT_W, 2, width of each per-register pending counter; max outstanding long writes per rd = 2**CNT_W-1.
- XREGS, 32, number of architectural registers (index width = $clog2(XREGS)).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- issue_valid_i  in  1  instruction in decode requests issue
- issue_rs_i  in  NUM_SRC*5  source register indices, operand k at [5k+4:5k]
- issue_rs_used_i  in  NUM_SRC  operand k actually read
- issue_rd_i  in  5  destination register
- issue_we_i  in  1  instruction writes rd
- issue_long_i  in  1  rd produced by long-latency unit (load/MDU)
- flush_i  in  1  kill instruction in decode (no issue this cycle)
- ex_we_i, ex_rd_i, ex_rdy_i  in  1,5,1  E-stage write enable, rd, result valid in E
- mem_we_i, mem_rd_i  in  1,5  M-stage write enable, rd
- wb_we_i, wb_rd_i, wb_long_i  in  1,5,1  W-stage write; wb_long_i marks long-op completion
- fwd_sel_o  out  NUM_SRC*2  per-operand bypass select (fwd_sel_t)
- stall_o  out  1  hold decode/issue
- issue_ack_o  out  1  instruction accepted this cycle
- pending_o  out  XREGS  per-register "counter != 0"
- stall_raw_cnt_o, stall_waw_cnt_o  out  32,32  stall statistics (see Optional Feature)

Behaviour:
- Clock/reset: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset: all counters 0. While rst_i is high, fwd_sel_o=NO_BYPASS, stall_o=0, issue_ack_o=0, pending_o=0.
- Forward select per used operand k with rs!=0, priority E > M > W:
  - ex_we_i & ex_rd_i==rs & ex_rdy_i -> BYPASS_E
  - else mem_we_i & mem_rd_i==rs -> BYPASS_M
  - else wb_we_i & wb_rd_i==rs -> BYPASS_W
  - else NO_BYPASS
  - rs==0 or operand unused -> always NO_BYPASS.
- RAW stall: any used rs!=0 with either
  - ex_we_i & ex_rd_i==rs & !ex_rdy_i, or
  - cnt[rs]!=0, unless wb_long_i & wb_we_i & wb_rd_i==rs & cnt[rs]==1 (forwarded from W, no stall).
- WAW stall: issue_we_i & issue_long_i & issue_rd_i!=0 & cnt[rd]==2**CNT_W-1 (counter full).
- stall_o = issue_valid_i & !flush_i & (RAW | WAW). All select/stall outputs are combinational from inputs and registered counters; zero-cycle latency.
- issue_ack_o = issue_valid_i & !flush_i & !stall_o.
- Counter update (registered, next edge):
  - inc when issue_ack_o & issue_we_i & issue_long_i & rd!=0
  - dec when wb_long_i & wb_we_i & wb_rd_i!=0
  - inc and dec on the same register in the same cycle -> unchanged.
  - dec at 0 is illegal: hold at 0; assertion fires in simulation.
- Flush: suppresses issue/inc only. Long ops already issued always complete via wb_long_i; counters are never cleared by flush.
- Reset mid-operation: counters cleared on the edge; in-flight writebacks after reset are ignored by the dec-at-0 rule.
- x0 is never tracked, never stalls and never forwards.

Optional Feature:
- Macro MIRISCV_HAZARD_STAT_EN.
- Defined: two 32-bit wrap-around counters, reset to 0.
  - stall_raw_cnt_o increments each cycle stall_o is caused by RAW.
  - stall_waw_cnt_o increments each cycle stall_o is caused only by WAW.
- Undefined: both ports tied to 32'h0; no flops inferred.

Decomposition:
- New package miriscv_hazard_pkg holds:
  - fwd_sel_t, a 2-bit enum: NO_BYPASS=0, BYPASS_E=1, BYPASS_M=2, BYPASS_W=3 (first three keep existing encodings).
  - Default CNT_W.
- Sub-module miriscv_scoreboard: the XREGS-entry counter array with inc/dec ports and pending_o/full outputs.
- Top level keeps the compare/priority logic, stall logic and statistics.

Test Plan:
- Reset held 3 cycles after random traffic -> pending_o=0, stall_o=0, fwd_sel_o=0; first post-reset long issue to x5 -> pending_o[5]=1 next cycle.
- ALU x3 in E (ex_rdy_i=1) and ALU x3 in M, decode reads rs1=x3 -> fwd_sel[0]=BYPASS_E, no stall; remove E write -> BYPASS_M; x0 operand always NO_BYPASS.
- Load to x7 in E (ex_rdy_i=0), rs2=x7 -> stall_o=1, issue_ack_o=0; next cycle load in M -> BYPASS_M, stall 0.
- MDU to x9 issued (cnt=1), dependant waits; stall_o=1 until the wb_long_i cycle for x9, where fwd_sel=BYPASS_W and issue_ack_o=1.
- CNT_W=2: three long ops to x4 accepted, fourth -> WAW stall; a simultaneous wb_long_i on x4 plus issue keeps cnt=3 and the stall clears.
- MIRISCV_HAZARD_STAT_EN defined: 4 RAW stall cycles then 2 WAW-only cycles -> stall_raw_cnt_o=4, stall_waw_cnt_o=2; undefined -> both read 0.

Source files
------------

// File: rtl/miriscv_hazard_pkg.sv
// miriscv_hazard_pkg: bypass select encoding and defaults for the hazard scoreboard
package miriscv_hazard_pkg;
  typedef enum logic [1:0] {
    NO_BYPASS = 2'd0,
    BYPASS_E  = 2'd1,
    BYPASS_M  = 2'd2,
    BYPASS_W  = 2'd3
  } fwd_sel_t;
  localparam int CNT_W_DEF = 2;
endpackage

// File: rtl/miriscv_scoreboard.sv
// miriscv_scoreboard: per-register counters of outstanding long-latency writes
module miriscv_scoreboard #(
  parameter int XREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic [4:0]       inc_idx_i,
  input  logic             dec_i,
  input  logic [4:0]       dec_idx_i,
  output logic [XREGS-1:0] pending_o,
  output logic [XREGS-1:0] one_o,
  output logic [XREGS-1:0] full_o
);
  logic [CNT_W-1:0] cnt_q [XREGS];
  logic [CNT_W-1:0] cnt_d [XREGS];
  logic [XREGS-1:0] inc_v, dec_v;
  // status kept apart from the update so issue_ack -> inc does not form a block-level loop
  always_comb begin
    for (int i = 0; i < XREGS; i++) begin
      dec_v[i] = dec_i && dec_idx_i == 5'(i) && i != 0;
      pending_o[i] = cnt_q[i] != '0;
      one_o[i] = cnt_q[i] == CNT_W'(1);
      full_o[i] = &cnt_q[i] && !dec_v[i];
    end
  end
  always_comb begin
    for (int i = 0; i < XREGS; i++) begin
      inc_v[i] = inc_i && inc_idx_i == 5'(i) && i != 0;
      cnt_d[i] = (inc_v[i] && !dec_v[i]) ? cnt_q[i] + 1'b1 :
                 (dec_v[i] && !inc_v[i] && pending_o[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  end
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && dec_idx_i != 5'd0 && cnt_q[dec_idx_i] == '0));
endmodule

// File: rtl/miriscv_hazard_scoreboard.sv
// miriscv_hazard_scoreboard: E/M/W operand bypass, RAW/WAW issue stall, long-write scoreboard
// Stall statistics counters are built only when MIRISCV_HAZARD_STAT_EN is defined.
module miriscv_hazard_scoreboard
  import miriscv_hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int XREGS   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   issue_valid_i,
  input  logic [NUM_SRC*5-1:0]   issue_rs_i,
  input  logic [NUM_SRC-1:0]     issue_rs_used_i,
  input  logic [4:0]             issue_rd_i,
  input  logic                   issue_we_i,
  input  logic                   issue_long_i,
  input  logic                   flush_i,
  input  logic                   ex_we_i,
  input  logic [4:0]             ex_rd_i,
  input  logic                   ex_rdy_i,
  input  logic                   mem_we_i,
  input  logic [4:0]             mem_rd_i,
  input  logic                   wb_we_i,
  input  logic [4:0]             wb_rd_i,
  input  logic                   wb_long_i,
  output logic [NUM_SRC*2-1:0]   fwd_sel_o,
  output logic                   stall_o,
  output logic                   issue_ack_o,
  output logic [XREGS-1:0]       pending_o,
  output logic [31:0]            stall_raw_cnt_o,
  output logic [31:0]            stall_waw_cnt_o
);
  logic [XREGS-1:0] pend, one, full;
  logic [NUM_SRC-1:0] raw_v;
  logic [NUM_SRC*2-1:0] fwd;
  logic raw, waw, req, wb_dec;
  assign wb_dec = wb_long_i && wb_we_i && wb_rd_i != 5'd0;
  miriscv_scoreboard #(.XREGS(XREGS), .CNT_W(CNT_W)) u_sb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (issue_ack_o && issue_we_i && issue_long_i),
    .inc_idx_i (issue_rd_i),
    .dec_i     (wb_dec),
    .dec_idx_i (wb_rd_i),
    .pending_o (pend),
    .one_o     (one),
    .full_o    (full)
  );
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [4:0] rs;
    logic use_rs, e_hit, m_hit, w_hit;
    assign rs = issue_rs_i[5*k +: 5];
    assign use_rs = issue_rs_used_i[k] && rs != 5'd0;
    assign e_hit = ex_we_i && ex_rd_i == rs;
    assign m_hit = mem_we_i && mem_rd_i == rs;
    assign w_hit = wb_we_i && wb_rd_i == rs;
    assign fwd[2*k +: 2] = !use_rs ? NO_BYPASS : (e_hit && ex_rdy_i) ? BYPASS_E :
                           m_hit ? BYPASS_M : w_hit ? BYPASS_W : NO_BYPASS;
    // last outstanding long write landing in W this cycle is caught by the W bypass
    assign raw_v[k] = use_rs && ((e_hit && !ex_rdy_i) || (pend[rs] && !(wb_dec && w_hit && one[rs])));
  end
  always_comb begin
    raw = |raw_v;
    waw = issue_we_i && issue_long_i && issue_rd_i != 5'd0 && full[issue_rd_i];
    req = !rst_i && issue_valid_i && !flush_i;
    stall_o = req && (raw || waw);
    issue_ack_o = req && !raw && !waw;
    fwd_sel_o = rst_i ? '0 : fwd;
    pending_o = rst_i ? '0 : pend;
  end
`ifdef MIRISCV_HAZARD_STAT_EN
  logic [31:0] stall_raw_cnt_q, stall_raw_cnt_d, stall_waw_cnt_q, stall_waw_cnt_d;
  always_comb begin
    stall_raw_cnt_d = stall_raw_cnt_q + 32'(stall_o && raw);
    stall_waw_cnt_d = stall_waw_cnt_q + 32'(stall_o && !raw && waw);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_raw_cnt_q <= '0;
      stall_waw_cnt_q <= '0;
    end else begin
      stall_raw_cnt_q <= stall_raw_cnt_d;
      stall_waw_cnt_q <= stall_waw_cnt_d;
    end
  end
  assign stall_raw_cnt_o = stall_raw_cnt_q;
  assign stall_waw_cnt_o = stall_waw_cnt_q;
`else
  assign stall_raw_cnt_o = 32'h0;
  assign stall_waw_cnt_o = 32'h0;
`endif
endmodule

// File: tb/tb_miriscv_hazard_scoreboard.sv
// tb_miriscv_hazard_scoreboard: vector table, directed corner sequences and randomized model check
module tb_miriscv_hazard_scoreboard;
  localparam int MAXC = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, valid, flush, we, lng, exw, exy, mw, ww, wl;
  logic [4:0] rs0, rs1, rd, exr, mr, wr;
  logic [1:0] used;
  logic [3:0] fwd_sel_o;
  logic stall_o, issue_ack_o;
  logic [31:0] pending_o, sraw, swaw;
  int cnt_m [32];
  int passed = 0;
  int total = 0;

  typedef struct {
    logic [4:0] rs0; logic u0; logic [4:0] rs1; logic u1; logic fl;
    logic exw; logic [4:0] exr; logic exy; logic mw; logic [4:0] mr;
    logic ww; logic [4:0] wr; logic [1:0] s0; logic [1:0] s1; logic st;
  } vec_t;
  vec_t tbl [10];

  miriscv_hazard_scoreboard dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(valid), .issue_rs_i({rs1, rs0}),
    .issue_rs_used_i(used), .issue_rd_i(rd), .issue_we_i(we), .issue_long_i(lng),
    .flush_i(flush), .ex_we_i(exw), .ex_rd_i(exr), .ex_rdy_i(exy),
    .mem_we_i(mw), .mem_rd_i(mr), .wb_we_i(ww), .wb_rd_i(wr), .wb_long_i(wl),
    .fwd_sel_o(fwd_sel_o), .stall_o(stall_o), .issue_ack_o(issue_ack_o),
    .pending_o(pending_o), .stall_raw_cnt_o(sraw), .stall_waw_cnt_o(swaw)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic idle();
    valid = 0; flush = 0; we = 0; lng = 0; used = 0; rs0 = 0; rs1 = 0; rd = 0;
    exw = 0; exr = 0; exy = 0; mw = 0; mr = 0; ww = 0; wr = 0; wl = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r);
    idle(); valid = 1; we = 1; lng = 1; rd = r;
  endtask

  // reference: spec rules applied to an integer count per register
  task automatic evaluate();
    logic [1:0] s [2];
    logic [4:0] r;
    logic raw, waw, st, ak;
    logic [31:0] pend;
    @(negedge clk);
    raw = 0;
    for (int k = 0; k < 2; k++) begin
      r = (k == 1) ? rs1 : rs0;
      s[k] = 2'd0;
      if (used[k] && r != 0) begin
        if (exw && exr == r && exy) s[k] = 2'd1;
        else if (mw && mr == r) s[k] = 2'd2;
        else if (ww && wr == r) s[k] = 2'd3;
        if (exw && exr == r && !exy) raw = 1;
        if (cnt_m[r] > 0 && !(wl && ww && wr == r && cnt_m[r] == 1)) raw = 1;
      end
    end
    waw = we && lng && rd != 0 && cnt_m[rd] == MAXC && !(wl && ww && wr == rd);
    st = valid && !flush && (raw || waw);
    ak = valid && !flush && !st;
    for (int i = 0; i < 32; i++) pend[i] = cnt_m[i] != 0;
    if (rst) begin
      s[0] = 0; s[1] = 0; st = 0; ak = 0; pend = 0;
    end
    chk("fwd_sel", 32'(fwd_sel_o), 32'({s[1], s[0]}));
    chk("stall", 32'(stall_o), 32'(st));
    chk("ack", 32'(issue_ack_o), 32'(ak));
    chk("pending", pending_o, pend);
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt_m[i] = 0;
    end else begin
      if (ak && we && lng && rd != 0 && !(wl && ww && wr == rd)) cnt_m[rd]++;
      if (wl && ww && wr != 0 && !(ak && we && lng && rd == wr) && cnt_m[wr] > 0) cnt_m[wr]--;
    end
  endtask

  initial begin
    tbl[0] = '{5'd3, 1, 5'd0, 1, 0, 1, 5'd3, 1, 1, 5'd3, 0, 5'd0, 2'd1, 2'd0, 0};
    tbl[1] = '{5'd3, 1, 5'd0, 0, 0, 0, 5'd0, 0, 1, 5'd3, 0, 5'd0, 2'd2, 2'd0, 0};
    tbl[2] = '{5'd3, 1, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd3, 2'd3, 2'd0, 0};
    tbl[3] = '{5'd0, 1, 5'd0, 1, 0, 1, 5'd0, 1, 1, 5'd0, 1, 5'd0, 2'd0, 2'd0, 0};
    tbl[4] = '{5'd3, 0, 5'd0, 0, 0, 1, 5'd3, 1, 1, 5'd3, 1, 5'd3, 2'd0, 2'd0, 0};
    tbl[5] = '{5'd0, 0, 5'd7, 1, 0, 1, 5'd7, 0, 0, 5'd0, 0, 5'd0, 2'd0, 2'd0, 1};
    tbl[6] = '{5'd0, 0, 5'd7, 1, 0, 0, 5'd0, 0, 1, 5'd7, 0, 5'd0, 2'd0, 2'd2, 0};
    tbl[7] = '{5'd5, 1, 5'd5, 1, 0, 1, 5'd5, 1, 1, 5'd5, 1, 5'd5, 2'd1, 2'd1, 0};
    tbl[8] = '{5'd6, 1, 5'd9, 1, 0, 0, 5'd0, 0, 1, 5'd6, 1, 5'd9, 2'd2, 2'd3, 0};
    tbl[9] = '{5'd0, 0, 5'd7, 1, 1, 1, 5'd7, 0, 0, 5'd0, 0, 5'd0, 2'd0, 2'd0, 0};
    for (int i = 0; i < 32; i++) cnt_m[i] = 0;
    idle();
    rst = 1;
    evaluate();
    cyc();
    evaluate();
    cyc();
    rst = 0;
    evaluate();

    for (int i = 0; i < 10; i++) begin
      cyc();
      idle();
      valid = 1; flush = tbl[i].fl;
      rs0 = tbl[i].rs0; rs1 = tbl[i].rs1; used = {tbl[i].u1, tbl[i].u0};
      exw = tbl[i].exw; exr = tbl[i].exr; exy = tbl[i].exy;
      mw = tbl[i].mw; mr = tbl[i].mr; ww = tbl[i].ww; wr = tbl[i].wr;
      @(negedge clk);
      chk($sformatf("tbl%0d_fwd", i), 32'(fwd_sel_o), 32'({tbl[i].s1, tbl[i].s0}));
      chk($sformatf("tbl%0d_stall", i), 32'(stall_o), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_ack", i), 32'(issue_ack_o), 32'(!tbl[i].fl && !tbl[i].st));
    end

    for (int n = 0; n < 2000; n++) begin
      int p;
      cyc();
      rst = $urandom_range(99) == 0;
      valid = $urandom_range(3) != 0;
      flush = $urandom_range(9) == 0;
      rs0 = 5'($urandom_range(7)); rs1 = 5'($urandom_range(7));
      used = 2'($urandom); rd = 5'($urandom_range(7));
      we = 1'($urandom); lng = $urandom_range(2) == 0;
      exw = 1'($urandom); exr = 5'($urandom_range(7)); exy = 1'($urandom);
      mw = 1'($urandom); mr = 5'($urandom_range(7));
      p = $urandom_range(7, 1);
      wr = 5'(p);
      if (cnt_m[p] > 0 && $urandom_range(1) == 1) begin
        ww = 1; wl = 1;
      end else begin
        ww = 1'($urandom); wl = 0;
      end
      evaluate();
    end

    for (int i = 0; i < 3; i++) begin
      cyc();
      idle(); rst = 1; valid = 1; used = 2'b01; rs0 = 3; exw = 1; exr = 3; exy = 1;
      we = 1; lng = 1; rd = 5;
      evaluate();
      chk("rst_fwd", 32'(fwd_sel_o), 0);
      chk("rst_stall", 32'(stall_o), 0);
      chk("rst_ack", 32'(issue_ack_o), 0);
      chk("rst_pending", pending_o, 0);
    end
    cyc(); rst = 0; issue(5); evaluate();
    chk("post_rst_ack", 32'(issue_ack_o), 1);
    cyc(); idle(); evaluate();
    chk("post_rst_pend5", pending_o, 32'h20);

    cyc(); issue(9); evaluate();
    chk("mdu_issue_ack", 32'(issue_ack_o), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); valid = 1; used = 2'b01; rs0 = 9; evaluate();
      chk("mdu_dep_stall", 32'(stall_o), 1);
      chk("mdu_dep_ack", 32'(issue_ack_o), 0);
    end
    cyc(); idle(); valid = 1; used = 2'b01; rs0 = 9; ww = 1; wl = 1; wr = 9; evaluate();
    chk("mdu_wb_fwd", 32'(fwd_sel_o), 32'h3);
    chk("mdu_wb_stall", 32'(stall_o), 0);
    chk("mdu_wb_ack", 32'(issue_ack_o), 1);
    cyc(); idle(); ww = 1; wl = 1; wr = 5; evaluate();
    chk("mdu_done_pend", pending_o, 32'h20);
    cyc(); idle(); evaluate();
    chk("drained_pend", pending_o, 0);

    for (int i = 0; i < 3; i++) begin
      cyc(); issue(4); evaluate();
      chk("waw_fill_ack", 32'(issue_ack_o), 1);
    end
    cyc(); issue(4); evaluate();
    chk("waw_full_stall", 32'(stall_o), 1);
    chk("waw_full_ack", 32'(issue_ack_o), 0);
    cyc(); issue(4); ww = 1; wl = 1; wr = 4; evaluate();
    chk("waw_swap_stall", 32'(stall_o), 0);
    chk("waw_swap_ack", 32'(issue_ack_o), 1);
    cyc(); issue(4); evaluate();
    chk("waw_still_full", 32'(stall_o), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); ww = 1; wl = 1; wr = 4; evaluate();
    end
    cyc(); idle(); evaluate();
    chk("waw_drained", pending_o, 0);

    cyc(); idle(); rst = 1; evaluate();
    cyc(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      issue(4); evaluate(); cyc();
    end
    for (int i = 0; i < 4; i++) begin
      idle(); valid = 1; used = 2'b01; rs0 = 7; exw = 1; exr = 7; exy = 0;
      evaluate(); cyc();
    end
    for (int i = 0; i < 2; i++) begin
      issue(4); evaluate();
      chk("stat_waw_stall", 32'(stall_o), 1);
      cyc();
    end
    idle(); evaluate();
`ifdef MIRISCV_HAZARD_STAT_EN
    chk("stat_raw", sraw, 4);
    chk("stat_waw", swaw, 2);
`else
    chk("stat_raw", sraw, 0);
    chk("stat_waw", swaw, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); ww = 1; wl = 1; wr = 4; evaluate();
    end
    cyc(); idle(); evaluate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
